// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Two-port arbiter/sequencer for a single-port data memory. Port 0 is the
//   CPU load/store path, port 1 a secondary master (debug/DMA). A request is
//   accepted in IDLE (reqN_ready high for the winner only). The next cycle
//   (ACCESS) drives the memory. The cycle after that returns a one-cycle
//   response on the granted port.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   reqN_valid/we/addr/wdata    request from port N (N = 0, 1)
//   reqN_ready                  request accepted this cycle (combinational)
//   rspN_valid/rdata            one-cycle completion pulse, read data (0 for writes)
//   mem_addr/wdata/write/read   memory command, active only in ACCESS
//   mem_rdata                   memory read data, combinational from mem_addr
//   busy                        high while in ACCESS
module data_mem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req1_ready,
  output logic              rsp0_valid,
  output logic [DATA_W-1:0] rsp0_rdata,
  output logic              rsp1_valid,
  output logic [DATA_W-1:0] rsp1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_write,
  output logic              mem_read,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic {
    IDLE   = 1'b0,
    ACCESS = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic              last_grant;
  logic              acc_we;
  logic              acc_port;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              grant0;
  logic              grant1;

  // Memory address/data hold the last latched request outside ACCESS.
  assign mem_addr  = acc_addr;
  assign mem_wdata = acc_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Arbitration and memory command decode.
  always_comb begin
    state_nxt  = state;
    grant0     = 1'b0;
    grant1     = 1'b0;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    mem_write  = 1'b0;
    mem_read   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        // Port 0 wins when alone, in fixed-priority mode, or when port 1
        // was the last port served.
        grant0 = req0_valid &&
                 ((FIXED_PRIO != 0) || !req1_valid || last_grant);
        grant1 = req1_valid && !grant0;
        // Ready must stay low while reset is held even though state is IDLE.
        req0_ready = grant0 && rst_n;
        req1_ready = grant1 && rst_n;
        if (grant0 || grant1) begin
          state_nxt = ACCESS;
        end
      end
      ACCESS: begin
        mem_write = acc_we;
        mem_read  = !acc_we;
        busy      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Request latch and response stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= 1'b1;
      acc_we     <= 1'b0;
      acc_port   <= 1'b0;
      acc_addr   <= '0;
      acc_wdata  <= '0;
      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      rsp0_rdata <= '0;
      rsp1_rdata <= '0;
    end else begin
      if (grant0) begin
        last_grant <= 1'b0;
        acc_port   <= 1'b0;
        acc_we     <= req0_we;
        acc_addr   <= req0_addr;
        acc_wdata  <= req0_wdata;
      end else if (grant1) begin
        last_grant <= 1'b1;
        acc_port   <= 1'b1;
        acc_we     <= req1_we;
        acc_addr   <= req1_addr;
        acc_wdata  <= req1_wdata;
      end

      rsp0_valid <= 1'b0;
      rsp1_valid <= 1'b0;
      if (state == ACCESS) begin
        // Only the granted port's read data register changes.
        if (acc_port) begin
          rsp1_valid <= 1'b1;
          rsp1_rdata <= acc_we ? '0 : mem_rdata;
        end else begin
          rsp0_valid <= 1'b1;
          rsp0_rdata <= acc_we ? '0 : mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter
//   Directed bench for data_mem_arbiter. A round-robin instance is attached
//   to a behavioural 64K x 16 memory. A fixed-priority instance is attached to
//   a stub memory that returns the inverted address.
module tb_data_mem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req0_valid, req0_we, req1_valid, req1_we;
  logic [15:0] req0_addr, req0_wdata, req1_addr, req1_wdata;
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [15:0] rsp0_rdata, rsp1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        mem_write, mem_read, busy;

  logic        f_req0_valid, f_req1_valid;
  logic [15:0] f_req0_addr, f_req1_addr;
  logic        f_req0_ready, f_req1_ready, f_rsp0_valid, f_rsp1_valid;
  logic [15:0] f_rsp0_rdata, f_rsp1_rdata, f_mem_addr, f_mem_wdata, f_mem_rdata;
  logic        f_mem_write, f_mem_read, f_busy;

  logic [15:0] mem [0:65535];

  int checks = 0;
  int errors = 0;

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
    .req0_wdata(req0_wdata), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
    .req1_wdata(req1_wdata), .req1_ready(req1_ready),
    .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
    .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata), .busy(busy)
  );

  data_mem_arbiter #(.ADDR_W(16), .DATA_W(16), .FIXED_PRIO(1)) dut_fp (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(f_req0_valid), .req0_we(1'b0), .req0_addr(f_req0_addr),
    .req0_wdata(16'h0000), .req0_ready(f_req0_ready),
    .req1_valid(f_req1_valid), .req1_we(1'b0), .req1_addr(f_req1_addr),
    .req1_wdata(16'h0000), .req1_ready(f_req1_ready),
    .rsp0_valid(f_rsp0_valid), .rsp0_rdata(f_rsp0_rdata),
    .rsp1_valid(f_rsp1_valid), .rsp1_rdata(f_rsp1_rdata),
    .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata), .mem_write(f_mem_write),
    .mem_read(f_mem_read), .mem_rdata(f_mem_rdata), .busy(f_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_write) mem[mem_addr] <= mem_wdata;
  end
  assign mem_rdata   = mem_read ? mem[mem_addr] : 16'h0000;
  assign f_mem_rdata = f_mem_read ? ~f_mem_addr : 16'h0000;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk1({tag, "_ready0"}, req0_ready, 1'b0);
    chk1({tag, "_ready1"}, req1_ready, 1'b0);
    chk1({tag, "_rsp0v"}, rsp0_valid, 1'b0);
    chk1({tag, "_rsp1v"}, rsp1_valid, 1'b0);
    chk16({tag, "_rsp0d"}, rsp0_rdata, 16'h0000);
    chk16({tag, "_rsp1d"}, rsp1_rdata, 16'h0000);
    chk16({tag, "_maddr"}, mem_addr, 16'h0000);
    chk16({tag, "_mwdata"}, mem_wdata, 16'h0000);
    chk1({tag, "_mwrite"}, mem_write, 1'b0);
    chk1({tag, "_mread"}, mem_read, 1'b0);
    chk1({tag, "_busy"}, busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic exp_port;
    mem[16'h0010] = 16'h1111;
    mem[16'h0020] = 16'h2222;
    rst_n = 1'b0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 16'h0004; req0_wdata = 16'hABCD;
    req1_valid = 1'b0; req1_we = 1'b0; req1_addr = 16'h0000; req1_wdata = 16'h0000;
    f_req0_valid = 1'b0; f_req1_valid = 1'b0;
    f_req0_addr = 16'h0030; f_req1_addr = 16'h0040;

    // Reset state, with a pending request that must not be readied.
    cyc(); cyc();
    chk_all_zero("reset");
    req0_valid = 1'b0;
    rst_n = 1'b1;
    cyc();

    // Port 0 write 0x0004 <= 0xABCD, then read it back.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 16'h0004; req0_wdata = 16'hABCD;
    #1;
    chk1("wr_ready0", req0_ready, 1'b1);
    chk1("wr_ready1", req1_ready, 1'b0);
    chk1("wr_idle_mwrite", mem_write, 1'b0);
    cyc();
    req0_valid = 1'b0;
    #1;
    chk1("wr_busy", busy, 1'b1);
    chk1("wr_mwrite", mem_write, 1'b1);
    chk1("wr_mread", mem_read, 1'b0);
    chk16("wr_maddr", mem_addr, 16'h0004);
    chk16("wr_mwdata", mem_wdata, 16'hABCD);
    chk1("wr_acc_ready0", req0_ready, 1'b0);
    cyc();
    req0_valid = 1'b1; req0_we = 1'b0;
    #1;
    chk1("wr_rsp0v", rsp0_valid, 1'b1);
    chk16("wr_rsp0d", rsp0_rdata, 16'h0000);
    chk1("wr_rsp1v", rsp1_valid, 1'b0);
    chk1("wr_mwrite_off", mem_write, 1'b0);
    chk16("wr_maddr_hold", mem_addr, 16'h0004);
    chk1("rd_ready0", req0_ready, 1'b1);
    cyc();
    req0_valid = 1'b0;
    #1;
    chk1("rd_mread", mem_read, 1'b1);
    chk1("rd_mwrite", mem_write, 1'b0);
    cyc();
    chk1("rd_rsp0v", rsp0_valid, 1'b1);
    chk16("rd_rsp0d", rsp0_rdata, 16'hABCD);
    chk1("rd_rsp1v", rsp1_valid, 1'b0);
    cyc();
    chk1("rd_rsp0v_pulse", rsp0_valid, 1'b0);
    chk16("rd_rsp0d_hold", rsp0_rdata, 16'hABCD);

    // Continuous contention; port 0 was served last, so port 1 goes first.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0020;
    exp_port = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk1("rr_ready0", req0_ready, !exp_port);
      chk1("rr_ready1", req1_ready, exp_port);
      if (i > 0) begin
        chk1("rr_rsp0v", rsp0_valid, exp_port);
        chk1("rr_rsp1v", rsp1_valid, !exp_port);
        if (exp_port) chk16("rr_rsp0d", rsp0_rdata, 16'h1111);
        else          chk16("rr_rsp1d", rsp1_rdata, 16'h2222);
      end
      cyc();
      chk1("rr_busy", busy, 1'b1);
      chk1("rr_acc_ready0", req0_ready, 1'b0);
      chk1("rr_acc_ready1", req1_ready, 1'b0);
      chk16("rr_maddr", mem_addr, exp_port ? 16'h0020 : 16'h0010);
      cyc();
      exp_port = !exp_port;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk1("rr_last_rsp0v", rsp0_valid, 1'b1);
    chk16("rr_last_rsp0d", rsp0_rdata, 16'h1111);
    cyc();

    // Port 1 writes 0x1234 to 0xFFFE, port 0 reads it back.
    req1_valid = 1'b1; req1_we = 1'b1; req1_addr = 16'hFFFE; req1_wdata = 16'h1234;
    #1;
    chk1("hi_ready1", req1_ready, 1'b1);
    cyc();
    req1_valid = 1'b0;
    chk16("hi_maddr", mem_addr, 16'hFFFE);
    chk1("hi_mwrite", mem_write, 1'b1);
    cyc();
    chk1("hi_rsp1v", rsp1_valid, 1'b1);
    chk16("hi_rsp1d", rsp1_rdata, 16'h0000);
    chk1("hi_rsp0v", rsp0_valid, 1'b0);
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'hFFFE;
    #1;
    chk1("hi_rd_ready0", req0_ready, 1'b1);
    cyc();
    req0_valid = 1'b0;
    chk1("hi_rd_mread", mem_read, 1'b1);
    chk16("hi_rd_maddr", mem_addr, 16'hFFFE);
    cyc();
    chk1("hi_rd_rsp0v", rsp0_valid, 1'b1);
    chk16("hi_rd_rsp0d", rsp0_rdata, 16'h1234);
    chk1("hi_rd_rsp1v", rsp1_valid, 1'b0);

    // Port 0 request withdrawn while port 1 holds the grant.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0020;
    #1;
    chk1("wd_ready1", req1_ready, 1'b1);
    chk1("wd_ready0", req0_ready, 1'b0);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk1("wd_acc_ready0", req0_ready, 1'b0);
    cyc();
    chk1("wd_rsp1v", rsp1_valid, 1'b1);
    chk16("wd_rsp1d", rsp1_rdata, 16'h2222);
    chk1("wd_rsp0v", rsp0_valid, 1'b0);
    chk1("wd_idle_ready0", req0_ready, 1'b0);
    cyc();
    chk1("wd_no_rsp0", rsp0_valid, 1'b0);
    chk1("wd_no_busy", busy, 1'b0);

    // Reset during the ACCESS cycle of a write.
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 16'h0006; req0_wdata = 16'h5678;
    #1;
    chk1("rst_ready0", req0_ready, 1'b1);
    cyc();
    req0_valid = 1'b0;
    chk1("rst_mwrite_pre", mem_write, 1'b1);
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    cyc();
    rst_n = 1'b1;
    cyc();
    chk1("rst_post_rsp0v", rsp0_valid, 1'b0);
    chk1("rst_post_rsp1v", rsp1_valid, 1'b0);
    cyc();
    chk1("rst_post2_rsp0v", rsp0_valid, 1'b0);

    // First contention after reset: 0 then 1.
    req0_valid = 1'b1; req0_we = 1'b0; req0_addr = 16'h0010;
    req1_valid = 1'b1; req1_we = 1'b0; req1_addr = 16'h0020;
    #1;
    chk1("prst_ready0", req0_ready, 1'b1);
    chk1("prst_ready1", req1_ready, 1'b0);
    cyc(); cyc();
    chk1("prst_ready1b", req1_ready, 1'b1);
    chk1("prst_rsp0v", rsp0_valid, 1'b1);
    chk16("prst_rsp0d", rsp0_rdata, 16'h1111);
    cyc();
    req0_valid = 1'b0; req1_valid = 1'b0;
    cyc();
    chk1("prst_rsp1v", rsp1_valid, 1'b1);
    chk16("prst_rsp1d", rsp1_rdata, 16'h2222);

    // Fixed-priority instance: port 0 always wins while valid.
    f_req0_valid = 1'b1; f_req1_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk1("fp_ready0", f_req0_ready, 1'b1);
      chk1("fp_ready1", f_req1_ready, 1'b0);
      cyc();
      chk1("fp_busy", f_busy, 1'b1);
      cyc();
    end
    f_req0_valid = 1'b0;
    #1;
    chk1("fp_rsp0v", f_rsp0_valid, 1'b1);
    chk16("fp_rsp0d", f_rsp0_rdata, 16'hFFCF);
    chk1("fp_ready1_after", f_req1_ready, 1'b1);
    cyc();
    f_req1_valid = 1'b0;
    cyc();
    chk1("fp_rsp1v", f_rsp1_valid, 1'b1);
    chk16("fp_rsp1d", f_rsp1_rdata, 16'hFFBF);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
